// File: rtl/blink_host_if.sv
// blink_host_if
// -------------
// Word-serial host front end for the registered Blink tweakable block-cipher
// core. The host writes a 1280-bit round-key bundle word by word, then streams
// eight 32-bit words (tweak MSW-first, then block MSW-first). The collected
// values are presented in parallel to the core. After the core's fixed
// register latency the 128-bit result is captured and streamed back out as
// four 32-bit words, MSW first.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   key_we     key word write strobe
//   key_addr   key word index 0..39; word i lands in core_K0[32i+31:32i]
//   key_wdata  key word
//   key_err    one-cycle pulse when a key write is dropped
//   in_valid   block-word valid
//   in_ready   block-word ready (only while collecting, low during rst)
//   in_data    block word (words 0-3 tweak, 4-7 block)
//   in_enc     direction, 1 = encrypt, sampled with word 0 only
//   out_valid  result-word valid
//   out_ready  result-word ready
//   out_data   result word
//   out_last   high on result word 3
//   core_enc   to core enc
//   core_K0    to core K0 (round-key bundle)
//   core_T     to core T (tweak)
//   core_P     to core P (block)
//   core_C     from core C (result)

module blink_host_if #(
  parameter int WORD     = 32,
  parameter int N        = 128,
  parameter int ROUNDS   = 20,
  parameter int CORE_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_we,
  input  logic [5:0]             key_addr,
  input  logic [WORD-1:0]        key_wdata,
  output logic                   key_err,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD-1:0]        in_data,
  input  logic                   in_enc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD-1:0]        out_data,
  output logic                   out_last,
  output logic                   core_enc,
  output logic [N*ROUNDS/2-1:0]  core_K0,
  output logic [N-1:0]           core_T,
  output logic [N-1:0]           core_P,
  input  logic [N-1:0]           core_C
);

  localparam int KEY_BITS  = N * ROUNDS / 2;
  localparam int KEY_WORDS = KEY_BITS / WORD;
  localparam int BLK_WORDS = N / WORD;
  localparam int IN_WORDS  = 2 * BLK_WORDS;
  localparam int CNT_W     = $clog2(IN_WORDS);
  localparam int OUT_W     = $clog2(BLK_WORDS);
  localparam int WAIT_W    = (CORE_LAT > 0) ? $clog2(CORE_LAT + 1) : 1;

  localparam logic [5:0]       KEY_LAST = 6'(KEY_WORDS - 1);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(BLK_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_WORDS - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_WAIT    = 2'd1,
    ST_SEND    = 2'd2
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  word_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [OUT_W-1:0]  out_cnt_reg;
  logic [OUT_W-1:0]  out_cnt_next;
  logic [N-1:0]      result_reg;
  logic              enc_reg;
  logic              key_err_reg;
  logic              out_valid_reg;
  logic              out_last_reg;
  logic [WORD-1:0]   out_data_reg;
  logic [WORD-1:0]   res_word [BLK_WORDS];

  logic in_fire;
  logic key_ok;
  logic key_fire;

  // in_ready is forced low while rst is asserted so nothing is accepted on
  // the reset edge even though the state register still reads COLLECT.
  assign in_ready = (state_reg == ST_COLLECT) && !rst;
  assign in_fire  = in_valid && in_ready;

  // Key writes are only safe before the first word of a block is taken;
  // after that the core inputs must stay frozen until the result is captured.
  assign key_ok   = (state_reg == ST_COLLECT) && (word_cnt_reg == '0) &&
                    (key_addr <= KEY_LAST);
  assign key_fire = key_we && key_ok;

  assign out_cnt_next = out_cnt_reg + OUT_W'(1);

  assign key_err   = key_err_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign out_data  = out_data_reg;
  assign core_enc  = enc_reg;

  genvar gi;

  // Round-key bundle: one register per 32-bit word, word i at bits 32i.
  generate
    for (gi = 0; gi < KEY_WORDS; gi++) begin : g_key
      logic [WORD-1:0] key_word_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          key_word_reg <= '0;
        end else if (key_fire && (key_addr == 6'(gi))) begin
          key_word_reg <= key_wdata;
        end
      end

      assign core_K0[WORD*gi +: WORD] = key_word_reg;
    end
  endgenerate

  // Tweak and block buffers. Word k of a group fills the k-th word from the
  // top, so word 0 is the MSW. The upper word-counter bit selects the group.
  generate
    for (gi = 0; gi < BLK_WORDS; gi++) begin : g_data
      logic [WORD-1:0] tweak_word_reg;
      logic [WORD-1:0] block_word_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          tweak_word_reg <= '0;
          block_word_reg <= '0;
        end else if (in_fire) begin
          if (word_cnt_reg == CNT_W'(gi)) begin
            tweak_word_reg <= in_data;
          end
          if (word_cnt_reg == CNT_W'(gi + BLK_WORDS)) begin
            block_word_reg <= in_data;
          end
        end
      end

      assign core_T[N-1-WORD*gi -: WORD] = tweak_word_reg;
      assign core_P[N-1-WORD*gi -: WORD] = block_word_reg;
      assign res_word[gi]                = result_reg[N-1-WORD*gi -: WORD];
    end
  endgenerate

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_COLLECT;
      word_cnt_reg  <= '0;
      wait_cnt_reg  <= '0;
      out_cnt_reg   <= '0;
      result_reg    <= '0;
      enc_reg       <= 1'b0;
      key_err_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      key_err_reg <= key_we && !key_ok;

      case (state_reg)
        ST_COLLECT: begin
          if (in_fire) begin
            if (word_cnt_reg == '0) begin
              enc_reg <= in_enc;
            end
            if (word_cnt_reg == CNT_LAST) begin
              word_cnt_reg <= '0;
              wait_cnt_reg <= WAIT_W'(CORE_LAT);
              state_reg    <= ST_WAIT;
            end else begin
              word_cnt_reg <= word_cnt_reg + CNT_W'(1);
            end
          end
        end

        ST_WAIT: begin
          // Core inputs changed on the last accept edge; the core samples
          // one edge later and updates C CORE_LAT-1 edges after that, so
          // capturing when the counter has run out sees the settled result.
          if (wait_cnt_reg != '0) begin
            wait_cnt_reg <= wait_cnt_reg - WAIT_W'(1);
          end else begin
            result_reg    <= core_C;
            out_data_reg  <= core_C[N-1 -: WORD];
            out_last_reg  <= (OUT_LAST == '0);
            out_valid_reg <= 1'b1;
            out_cnt_reg   <= '0;
            state_reg     <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (out_ready) begin
            if (out_cnt_reg == OUT_LAST) begin
              out_cnt_reg   <= '0;
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              out_data_reg  <= '0;
              state_reg     <= ST_COLLECT;
            end else begin
              out_cnt_reg  <= out_cnt_next;
              out_data_reg <= res_word[out_cnt_next];
              out_last_reg <= (out_cnt_next == OUT_LAST);
            end
          end
        end

        default: begin
          state_reg <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blink_host_if.sv
// Directed bench for blink_host_if. The cipher core is stood in for by a
// two-stage register pipeline computing C = enc ? P^T^K0[127:0] : P^T.
module tb_blink_host_if;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_we;
  logic [5:0]    key_addr;
  logic [31:0]   key_wdata;
  logic          key_err;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_enc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_last;
  logic          core_enc;
  logic [1279:0] core_K0;
  logic [127:0]  core_T;
  logic [127:0]  core_P;
  logic [127:0]  core_C;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  blink_host_if dut (
    .clk       (clk),
    .rst       (rst),
    .key_we    (key_we),
    .key_addr  (key_addr),
    .key_wdata (key_wdata),
    .key_err   (key_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_enc    (in_enc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .core_enc  (core_enc),
    .core_K0   (core_K0),
    .core_T    (core_T),
    .core_P    (core_P),
    .core_C    (core_C)
  );

  // Core stand-in: stage 1 samples inputs, stage 2 is the C register.
  logic [127:0] s1_p, s1_t, s1_k;
  logic         s1_enc;
  always @(posedge clk) begin
    if (rst) begin
      s1_p   <= '0;
      s1_t   <= '0;
      s1_k   <= '0;
      s1_enc <= 1'b0;
      core_C <= '0;
    end else begin
      s1_p   <= core_P;
      s1_t   <= core_T;
      s1_k   <= core_K0[127:0];
      s1_enc <= core_enc;
      core_C <= s1_enc ? (s1_p ^ s1_t ^ s1_k) : (s1_p ^ s1_t);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_key(input logic [5:0] addr, input logic [31:0] data,
                           input logic exp_err, input string tag);
    key_we    = 1'b1;
    key_addr  = addr;
    key_wdata = data;
    tick();
    key_we = 1'b0;
    check(tag, 128'(key_err), 128'(exp_err));
  endtask

  // Send words lo..hi of the 8-word frame (tweak then block). in_enc is
  // driven inverted on every word except 0 so a late sample would show up.
  task automatic send_range(input logic [127:0] t, input logic [127:0] p,
                            input logic enc, input int lo, input int hi,
                            input int gap_max);
    logic [127:0] src;
    int  n;
    int  g;
    bit  done;
    for (int k = lo; k <= hi; k++) begin
      if (gap_max > 0) begin
        g = $urandom_range(gap_max, 0);
        repeat (g) tick();
      end
      src      = (k < 4) ? t : p;
      in_data  = src[127-32*(k%4) -: 32];
      in_enc   = (k == 0) ? enc : ~enc;
      in_valid = 1'b1;
      done = 1'b0;
      n    = 0;
      while (!done && n < 50) begin
        done = in_ready;
        tick();
        n++;
      end
      in_valid = 1'b0;
      check($sformatf("in_accept_w%0d", k), 128'(done), 128'(1));
    end
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic recv_block(input logic [127:0] exp, input string tag,
                            input int stall_word, input int stall_cycles);
    logic [31:0] w;
    int n;
    for (int j = 0; j < 4; j++) begin
      w = exp[127-32*j -: 32];
      n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
      check($sformatf("%s_valid%0d", tag, j), 128'(out_valid), 128'(1));
      if (j == stall_word) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          tick();
          check($sformatf("%s_stall_data%0d", tag, s), 128'(out_data), 128'(w));
          check($sformatf("%s_stall_valid%0d", tag, s), 128'(out_valid), 128'(1));
        end
      end
      check($sformatf("%s_data%0d", tag, j), 128'(out_data), 128'(w));
      check($sformatf("%s_last%0d", tag, j), 128'(out_last), 128'(j == 3));
      $display("out word %0d: %08h (expected %08h) last=%0b", j, out_data, w, out_last);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check({tag, "_done_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_done_ready"}, 128'(in_ready), 128'(1));
  endtask

  localparam logic [127:0] P1     = 128'h11111111_22222222_33333333_44444444;
  // K0[127:0] = {key3,key2,key1,key0} = {4,3,2,1}, T = 0, encrypt.
  localparam logic [127:0] C1     = 128'h11111115_22222221_33333331_44444445;
  // Same frame after key word 0 is rewritten to 0x10.
  localparam logic [127:0] C1_K10 = 128'h11111115_22222221_33333331_44444454;
  localparam logic [127:0] TA5    = {16{8'hA5}};
  localparam logic [127:0] P5A    = {16{8'h5A}};
  localparam logic [127:0] ONES   = {128{1'b1}};

  initial begin
    int lat;
    rst       = 1'b1;
    key_we    = 1'b0;
    key_addr  = '0;
    key_wdata = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_enc    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_last", 128'(out_last), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    check("rst_key_err", 128'(key_err), 128'(0));
    check("rst_core_enc", 128'(core_enc), 128'(0));
    check("rst_core_T", core_T, 128'(0));
    check("rst_core_P", core_P, 128'(0));
    check("rst_core_K0_zero", 128'(core_K0 == '0), 128'(1));
    rst = 1'b0;
    #1;
    check("rel_in_ready", 128'(in_ready), 128'(1));

    // 1: encrypt with key words 0..3 = 1..4
    write_key(6'd0, 32'h1, 1'b0, "key0_err");
    write_key(6'd1, 32'h2, 1'b0, "key1_err");
    write_key(6'd2, 32'h3, 1'b0, "key2_err");
    write_key(6'd3, 32'h4, 1'b0, "key3_err");
    check("key_K0_low", core_K0[127:0], 128'h4_00000003_00000002_00000001);
    send_range(128'(0), P1, 1'b1, 0, 7, 0);
    check("enc1_core_enc", 128'(core_enc), 128'(1));
    wait_out(lat);
    check("enc1_latency", 128'(lat), 128'(3));
    recv_block(C1, "enc1", -1, 0);

    // 2: decrypt; in_valid held high during WAIT must not disturb buffers
    send_range(TA5, P5A, 1'b0, 0, 7, 0);
    check("dec_core_enc", 128'(core_enc), 128'(0));
    in_valid = 1'b1;
    in_data  = 32'hBAD0BAD0;
    wait_out(lat);
    in_valid = 1'b0;
    check("dec_latency", 128'(lat), 128'(3));
    check("dec_T_kept", core_T, TA5);
    check("dec_P_kept", core_P, P5A);
    recv_block(ONES, "dec", -1, 0);

    // 3: backpressure on word 1 for 5 cycles
    send_range(128'(0), P1, 1'b1, 0, 7, 0);
    wait_out(lat);
    recv_block(C1, "stall", 1, 5);

    // 4: key write after tweak word 2 is dropped, key unchanged
    send_range(128'(0), P1, 1'b1, 0, 2, 0);
    write_key(6'd0, 32'hDEADBEEF, 1'b1, "midkey_err");
    tick();
    check("midkey_err_pulse", 128'(key_err), 128'(0));
    check("midkey_K0_kept", core_K0[127:0], 128'h4_00000003_00000002_00000001);
    send_range(128'(0), P1, 1'b1, 3, 7, 0);
    wait_out(lat);
    recv_block(C1, "midkey", -1, 0);

    // key_addr out of range while idle
    write_key(6'd45, 32'hCAFEF00D, 1'b1, "addr45_err");
    tick();
    check("addr45_err_pulse", 128'(key_err), 128'(0));
    check("addr45_K0_zero_hi", 128'(core_K0[1279:128] == '0), 128'(1));

    // 5: random in_valid gaps give the same result
    send_range(128'(0), P1, 1'b1, 0, 7, 3);
    wait_out(lat);
    check("gap_latency", 128'(lat), 128'(3));
    recv_block(C1, "gap", -1, 0);

    // Simultaneous key write and word 0: both taken, new key used
    key_we    = 1'b1;
    key_addr  = 6'd0;
    key_wdata = 32'h10;
    send_range(128'(0), P1, 1'b1, 0, 0, 0);
    key_we = 1'b0;
    check("simkey_err", 128'(key_err), 128'(0));
    send_range(128'(0), P1, 1'b1, 1, 7, 0);
    wait_out(lat);
    recv_block(C1_K10, "simkey", -1, 0);

    // 6: reset during WAIT
    send_range(TA5, P1, 1'b1, 0, 7, 0);
    tick();
    rst = 1'b1;
    #1;
    check("wrst_in_ready_low", 128'(in_ready), 128'(0));
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("wrst_in_ready", 128'(in_ready), 128'(1));
    check("wrst_K0_zero", 128'(core_K0 == '0), 128'(1));
    check("wrst_T_zero", core_T, 128'(0));
    check("wrst_enc", 128'(core_enc), 128'(0));
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("wrst_out_valid%0d", i), 128'(out_valid), 128'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
